// File: rtl/rv64_muldiv_pkg.sv
// Shared constants, funct3 encodings and FSM state type for the RV64M mul/div unit.
package rv64_muldiv_pkg;
  localparam int XLEN  = 64;
  localparam int W_LEN = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
    return {{(XLEN-W_LEN){x[W_LEN-1]}}, x[W_LEN-1:0]};
  endfunction
endpackage

// File: rtl/rv64_muldiv_if.sv
// Request/result handshake bundle between register-file read stage, the mul/div unit and writeback.
interface rv64_muldiv_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [63:0] rs1_val;
  logic [63:0] rs2_val;
  logic [4:0]  rd_in;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  modport slave (
    input  in_valid, op, rs1_val, rs2_val, rd_in, kill, out_ready,
    output in_ready, out_valid, result, rd_out, busy
  );
  modport master (
    output in_valid, op, rs1_val, rs2_val, rd_in, kill, out_ready,
    input  in_ready, out_valid, result, rd_out, busy
  );
endinterface

// File: rtl/rv64_muldiv_core.sv
// Radix-2 iteration datapath on unsigned magnitudes: MSB-first shift-add multiply and
// restoring divide, one operand bit (selected by bit_idx) per step; init clears all state.
module rv64_muldiv_core
  import rv64_muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              init,
  input  logic              step,
  input  logic              is_div,
  input  logic [5:0]        bit_idx,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   quo,
  output logic [XLEN-1:0]   rem
);
  logic [XLEN:0] r_shift;
  logic [XLEN:0] r_sub;
  logic          ge;

  // One extra bit so the shifted partial remainder never overflows before the compare.
  assign r_shift = {rem, a[bit_idx]};
  assign r_sub   = r_shift - {1'b0, b};
  assign ge      = r_shift >= {1'b0, b};

  always_ff @(posedge clk) begin
    if (init) begin
      prod <= '0;
      quo  <= '0;
      rem  <= '0;
    end else if (step) begin
      if (is_div) begin
        rem <= ge ? r_sub[XLEN-1:0] : r_shift[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ge};
      end else begin
        prod <= {prod[2*XLEN-2:0], 1'b0} + (b[bit_idx] ? {{XLEN{1'b0}}, a} : {(2*XLEN){1'b0}});
      end
    end
  end
endmodule

// File: rtl/rv64_muldiv_unit.sv
// Iterative RV64M execute unit: special cases retire in 1 cycle, others take N+2 (N=64, W: 32).
// Result is held in DONE until out_ready; kill aborts any in-flight work.
module rv64_muldiv_unit
  import rv64_muldiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  rv64_muldiv_if.slave  io
);
  md_state_t       state;
  logic [5:0]      cnt;
  logic            is_w_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            neg_a, neg_b;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;
  logic            out_valid_q;

  logic            is_w, is_div, sgn_a, sgn_b, accept, special;
  logic [2:0]      f3;
  logic [XLEN-1:0] ext_a, ext_b, special_res, min_val;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, quo_s, rem_s, fix_val, fix_res;

  assign is_w   = io.op[3];
  assign f3     = io.op[2:0];
  assign is_div = f3[2];
  assign accept = io.in_valid & io.in_ready & ~io.kill;

  always_comb begin
    sgn_a = (f3 == MD_MULH) | (f3 == MD_MULHSU) | (f3 == MD_DIV) | (f3 == MD_REM);
    sgn_b = (f3 == MD_MULH) | (f3 == MD_DIV) | (f3 == MD_REM);
    ext_a = io.rs1_val;
    ext_b = io.rs2_val;
    if (is_w) begin
      ext_a = sgn_a ? sext32(io.rs1_val) : {32'b0, io.rs1_val[31:0]};
      ext_b = sgn_b ? sext32(io.rs2_val) : {32'b0, io.rs2_val[31:0]};
    end
    min_val     = is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    special     = 1'b0;
    special_res = '0;
    // Only MULW exists among W multiplies; the other W mul encodings produce zero.
    if (is_w && !is_div && f3 != MD_MUL) begin
      special = 1'b1;
    end else if (is_div && ext_b == '0) begin
      special     = 1'b1;
      special_res = f3[1] ? (is_w ? sext32(io.rs1_val) : io.rs1_val) : '1;
    end else if (is_div && sgn_a && ext_a == min_val && &ext_b) begin
      special     = 1'b1;
      special_res = f3[1] ? '0 : ext_a;
    end
  end

  always_comb begin
    prod_s  = (neg_a ^ neg_b) ? -prod : prod;
    quo_s   = (neg_a ^ neg_b) ? -quo : quo;
    rem_s   = neg_a ? -rem : rem;
    if (f3_q[2])
      fix_val = f3_q[1] ? rem_s : quo_s;
    else
      fix_val = (f3_q == MD_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    fix_res = is_w_q ? sext32(fix_val) : fix_val;
  end

  rv64_muldiv_core u_core (
    .clk     (clk),
    .init    (accept),
    .step    (state == CALC),
    .is_div  (f3_q[2]),
    .bit_idx (cnt),
    .a       (a_mag),
    .b       (b_mag),
    .prod    (prod),
    .quo     (quo),
    .rem     (rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
      cnt         <= '0;
    end else if (io.kill && state != IDLE) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          is_w_q <= is_w;
          f3_q   <= f3;
          rd_q   <= io.rd_in;
          neg_a  <= sgn_a & ext_a[XLEN-1];
          neg_b  <= sgn_b & ext_b[XLEN-1];
          a_mag  <= (sgn_a & ext_a[XLEN-1]) ? -ext_a : ext_a;
          b_mag  <= (sgn_b & ext_b[XLEN-1]) ? -ext_b : ext_b;
          if (special) begin
            result_q    <= special_res;
            rd_out_q    <= io.rd_in;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt   <= is_w ? 6'd31 : 6'd63;
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) state <= FIX;
        end
        FIX: begin
          result_q    <= fix_res;
          rd_out_q    <= rd_q;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: if (io.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = (state == IDLE) & ~rst;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.rd_out    = rd_out_q;
  assign io.busy      = (state != IDLE);
endmodule

// File: tb/tb_rv64_muldiv_unit.sv
// Directed-vector bench for rv64_muldiv_unit: results, latencies, back-pressure, kill and reset.
module tb_rv64_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  rv64_muldiv_if bus();
  rv64_muldiv_unit dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.op       = op;
    bus.rs1_val  = a;
    bus.rs2_val  = b;
    bus.rd_in    = rd;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [63:0] a,
                     input logic [63:0] b, input logic [4:0] rd,
                     input logic [63:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b, rd);
    lat = 1;
    while (!bus.out_valid && lat < 150) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " rd"}, 64'(bus.rd_out), 64'(rd));
    @(posedge clk); #1;
    chk({tag, " retire"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int seen;
    int lat;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.rs1_val   = '0;
    bus.rs2_val   = '0;
    bus.rd_in     = '0;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset result", bus.result, 64'd0);
    chk("reset rd_out", 64'(bus.rd_out), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle in_ready", 64'(bus.in_ready), 64'd1);

    run("MUL 7*-3",    4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    run("MULHU max",   4'b0011, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run("MULH -1*-1",  4'b0001, '1, '1, 5'd3, 64'd0, 66);
    run("MULHSU -1*2", 4'b0010, '1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    run("DIV -20/3",   4'b0100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd5, 64'hFFFF_FFFF_FFFF_FFFA, 66);
    run("REM -20/3",   4'b0110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    run("DIVU 100/7",  4'b0101, 64'd100, 64'd7, 5'd7, 64'd14, 66);
    run("DIV 5/0",     4'b0100, 64'd5, 64'd0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run("REMU 5/0",    4'b0111, 64'd5, 64'd0, 5'd9, 64'd5, 1);
    run("DIV ovf",     4'b0100, 64'h8000_0000_0000_0000, '1, 5'd10, 64'h8000_0000_0000_0000, 1);
    run("REM ovf",     4'b0110, 64'h8000_0000_0000_0000, '1, 5'd11, 64'd0, 1);
    run("DIVW -10/2",  4'b1100, 64'h0000_0000_FFFF_FFF6, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFB, 34);
    run("MULW",        4'b1000, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run("illegal W",   4'b1001, 64'd123, 64'd5, 5'd14, 64'd0, 1);

    // Back-pressure: result held while writeback stalls.
    bus.out_ready = 1'b0;
    issue(4'b0101, 64'd100, 64'd7, 5'd9);
    lat = 1;
    while (!bus.out_valid && lat < 150) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd66);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp result", bus.result, 64'd14);
      chk("bp rd_out", 64'(bus.rd_out), 64'd9);
      chk("bp in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp retire out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp retire in_ready", 64'(bus.in_ready), 64'd1);

    // kill while idle blocks the request in that cycle.
    bus.kill     = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 4'b0000;
    @(posedge clk); #1;
    bus.kill     = 1'b0;
    bus.in_valid = 1'b0;
    chk("idle kill busy", 64'(bus.busy), 64'd0);

    // kill in the 20th CALC cycle.
    issue(4'b0000, 64'd7, 64'd3, 5'd15);
    repeat (19) @(posedge clk);
    #1;
    chk("pre-kill busy", 64'(bus.busy), 64'd1);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    chk("kill busy", 64'(bus.busy), 64'd0);
    chk("kill out_valid", 64'(bus.out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("kill no result", 64'(seen), 64'd0);

    // Reset mid-CALC discards the operation.
    issue(4'b0101, 64'd100, 64'd7, 5'd16);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid rst result", bus.result, 64'd0);
    chk("mid rst rd_out", 64'(bus.rd_out), 64'd0);
    chk("mid rst busy", 64'(bus.busy), 64'd0);
    chk("mid rst in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    run("post rst DIV", 4'b0100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd17, 64'hFFFF_FFFF_FFFF_FFFA, 66);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
